// File: rtl/rc_pkg.sv
// Shared types and defaults for the reconfiguration request arbiter.
package rc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SWAP = 2'd2
    } rc_state_e;

    localparam int RC_NUM_SRC_DEF = 4;
    localparam int RC_TIMEOUT_DEF = 1024;

    // Width of a source index; never below one bit.
    function automatic int rc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_rr_pick.sv
// Combinational round-robin picker: first pending index at or after the pointer, wrapping.
module rc_rr_pick
    import rc_pkg::*;
#(
    parameter int NUM_SRC = RC_NUM_SRC_DEF,
    parameter int IW      = rc_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] pend_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      idx_o,
    output logic               valid_o
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest pending source wins.
    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = IW'(cand);
            if (pend_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc_req_arbiter.sv
// Round-robin requester for the reconfiguration handshake: drives active-low rc_reqn,
// grants the winner on acknowledge and abandons the request after TIMEOUT cycles.
module rc_req_arbiter
    import rc_pkg::*;
#(
    parameter int  NUM_SRC = RC_NUM_SRC_DEF,
    parameter int  TIMEOUT = RC_TIMEOUT_DEF,
    localparam int IW      = rc_idx_w(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               rc_ackn,
    input  logic               swap_done,
    output logic               rc_reqn,
    output logic               swap_start,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy,
    output logic               err_timeout,
    output logic [IW-1:0]      err_src
);

    localparam int            TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    rc_state_e          state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] clr_mask;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [IW-1:0]      sel_next;
    logic [TW-1:0]      timer_q, timer_d;
    logic               rc_reqn_q, rc_reqn_d;
    logic               swap_start_q, swap_start_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               err_timeout_q, err_timeout_d;
    logic [IW-1:0]      err_src_q, err_src_d;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;

    rc_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_pick (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign sel_next = (sel_q == IW'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_d         = sel_q;
        timer_d       = timer_q;
        rc_reqn_d     = rc_reqn_q;
        swap_start_d  = 1'b0;
        grant_d       = grant_q;
        err_timeout_d = 1'b0;
        err_src_d     = err_src_q;
        clr_mask      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d     = pick_idx;
                    rc_reqn_d = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                timer_d = timer_q + 1'b1;
                // An acknowledge in the final timeout cycle still wins.
                if (!rc_ackn) begin
                    rc_reqn_d       = 1'b1;
                    clr_mask[sel_q] = 1'b1;
                    swap_start_d    = 1'b1;
                    grant_d         = NUM_SRC'(1) << sel_q;
                    ptr_d           = sel_next;
                    state_d         = ST_SWAP;
                end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
                    rc_reqn_d       = 1'b1;
                    clr_mask[sel_q] = 1'b1;
                    err_timeout_d   = 1'b1;
                    err_src_d       = sel_q;
                    ptr_d           = sel_next;
                    state_d         = ST_IDLE;
                end
            end
            ST_SWAP: begin
                rc_reqn_d = 1'b1;
                if (swap_done) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request on the clearing edge re-queues the source.
        pend_d = (pend_q & ~clr_mask) | src_req;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            ptr_q         <= '0;
            sel_q         <= '0;
            timer_q       <= '0;
            rc_reqn_q     <= 1'b1;
            swap_start_q  <= 1'b0;
            grant_q       <= '0;
            err_timeout_q <= 1'b0;
            err_src_q     <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            ptr_q         <= ptr_d;
            sel_q         <= sel_d;
            timer_q       <= timer_d;
            rc_reqn_q     <= rc_reqn_d;
            swap_start_q  <= swap_start_d;
            grant_q       <= grant_d;
            err_timeout_q <= err_timeout_d;
            err_src_q     <= err_src_d;
        end
    end

    assign rc_reqn     = rc_reqn_q;
    assign swap_start  = swap_start_q;
    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_timeout_q;
    assign err_src     = err_src_q;

endmodule
